// File: rtl/booth_ctrl_pkg.sv
// Shared types and helpers for the booth multiplier arbiter.
package booth_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } arb_state_t;

    // Radix-4 booth: one 3-cycle step per recoded digit pair.
    function automatic int booth_latency(input int b_width);
        return 3 * ((b_width + 2) / 2);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter starting its search at ptr.
// Defining BOOTH_ARB_FIXED_PRIO_EN turns it into lowest-index-wins fixed priority.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

`ifdef BOOTH_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
`ifdef BOOTH_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(ptr) + k) % N;
`endif
            if (!any && req[idx]) begin
                any        = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one sequential booth multiplier between N_REQ requesters and returns tagged products.
// Macro BOOTH_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module booth_mult_arbiter
    import booth_ctrl_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int A_WIDTH      = 6,
    parameter int B_WIDTH      = 6,
    parameter int P_WIDTH      = A_WIDTH + B_WIDTH + 1,
    parameter int MULT_LATENCY = booth_latency(B_WIDTH),
    parameter int ID_W         = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*A_WIDTH-1:0]   req_a,
    input  logic [N_REQ*B_WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [P_WIDTH-1:0]         rsp_p,
    output logic                       mult_load,
    output logic [A_WIDTH-1:0]         mult_a,
    output logic [B_WIDTH-1:0]         mult_b,
    input  logic [P_WIDTH-1:0]         mult_p,
    output logic                       busy
);

    localparam int CNT_W = $clog2(MULT_LATENCY + 1);

    // state | meaning: IDLE arbitrate | LOAD load pulse | WAIT count latency | RESP hold response
    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             any;

    rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign req_ready = (state == IDLE && !rst) ? gnt : '0;
    assign busy      = (state != IDLE);

`ifdef BOOTH_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
            mult_load <= 1'b0;
            mult_a    <= '0;
            mult_b    <= '0;
`ifdef BOOTH_ARB_FIXED_PRIO_EN
`else
            ptr       <= '0;
`endif
        end else begin
            mult_load <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    mult_a    <= req_a[int'(gnt_idx)*A_WIDTH +: A_WIDTH];
                    mult_b    <= req_b[int'(gnt_idx)*B_WIDTH +: B_WIDTH];
                    rsp_id    <= gnt_idx;
                    mult_load <= 1'b1;
                    state     <= LOAD;
`ifdef BOOTH_ARB_FIXED_PRIO_EN
`else
                    ptr       <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
                end
                LOAD: begin
                    cnt   <= CNT_W'(MULT_LATENCY);
                    state <= WAIT;
                end
                WAIT: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    rsp_p     <= mult_p;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
